// File: rtl/cpu_pipeline_pkg.sv
// Shared widths, constants and types for the instruction fetch path.
package cpu_pipeline_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} ifu_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of {pc, instruction} entries: the head is readable the cycle
// after it is pushed, and a push into a full FIFO is allowed alongside a pop.
module fetch_fifo
  import cpu_pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Prefetching instruction fetch unit with in-order memory responses and branch flush.
// Define IFU_PERF_CNT_EN to add the perf_fetched / perf_flushes counter ports.
module instruction_fetch_unit
  import cpu_pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [XLEN-1:0]    if_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  ifu_state_t       state_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [CNT_W-1:0] discard_reg;
  logic [CNT_W-1:0] discard_next;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W:0]   in_use;

  fetch_entry_t     pcq_head;
  fetch_entry_t     pcq_wr;
  logic [CNT_W-1:0] pcq_count;
  logic             pcq_full;
  logic             pcq_empty;

  fetch_entry_t     buf_head;
  fetch_entry_t     buf_wr;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;

  logic             issue;
  logic             rsp_accept;
  logic             buf_pop;
  logic             unused_bits;

  // Requests still owed by memory: live ones in the PC queue plus ones to drop.
  assign outstanding = pcq_count + discard_reg;
  assign in_use      = {1'b0, outstanding} + {1'b0, buf_count};

  assign imem_req   = (state_reg == FETCH) && !branch_taken && (in_use < DEPTH_L);
  assign imem_addr  = pc_reg;
  assign issue      = imem_req && imem_ready;
  // An empty PC queue means the response belongs to nothing issued since reset.
  assign rsp_accept = imem_rvalid && !branch_taken && (state_reg != FLUSH) && !pcq_empty;

  assign if_valid       = !buf_empty && !branch_taken;
  assign buf_pop        = if_valid && if_ready;
  assign if_instruction = buf_empty ? '0 : buf_head.instr;
  assign if_pc          = buf_empty ? '0 : buf_head.pc;

  assign pcq_wr = '{pc: pc_reg, instr: '0};
  assign buf_wr = '{pc: pcq_head.pc, instr: imem_rdata};

  assign unused_bits = ^{pcq_head.instr, pcq_full, buf_full};

  always_comb begin
    discard_next = outstanding;
    if (imem_rvalid && (outstanding != '0)) begin
      discard_next = outstanding - CNT_W'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clock   (clock),
    .reset   (reset),
    .push    (issue),
    .pop     (rsp_accept),
    .clear   (branch_taken),
    .wr_data (pcq_wr),
    .rd_data (pcq_head),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (pcq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_prefetch_buf (
    .clock   (clock),
    .reset   (reset),
    .push    (rsp_accept),
    .pop     (buf_pop),
    .clear   (branch_taken),
    .wr_data (buf_wr),
    .rd_data (buf_head),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      discard_reg <= '0;
    end else if (branch_taken) begin
      pc_reg      <= branch_target;
      discard_reg <= discard_next;
      state_reg   <= (discard_next != '0) ? FLUSH : FETCH;
    end else begin
      if (issue) pc_reg <= pc_reg + PC_INC;
      case (state_reg)
        IDLE:  state_reg <= FETCH;
        FETCH: state_reg <= FETCH;
        FLUSH: begin
          if (imem_rvalid) begin
            discard_reg <= discard_reg - CNT_W'(1);
            if (discard_reg == CNT_W'(1)) state_reg <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (buf_pop && (perf_fetched != '1))      perf_fetched <= perf_fetched + 32'd1;
      if (branch_taken && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based reference model.
// Define IFU_PERF_CNT_EN to also exercise the performance counters.
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: memory in-flight queue, expected buffer, discard budget, next PC.
  logic [63:0] mem_q[$];
  ent_t        buf_q[$];
  int          discard;
  logic [63:0] exp_pc;
  int          model_pops;
  int          model_flushes;

  logic [63:0] issue_log[$];
  logic [63:0] pop_log[$];
  int          pop_cyc[$];
  int          dut_pops;
  int          cyc;

  int          ready_pct;
  int          rsp_pct;
  int          pop_pct;
  bit          br_req;
  logic [63:0] br_tgt;
  bit          verbose;

  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    discard       = 0;
    exp_pc        = RESET_PC;
    model_pops    = 0;
    model_flushes = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    bit          rv;
    bit          exp_valid;
    bit          exp_req;
    logic [63:0] raddr;
    ent_t        e;
    @(posedge clock);
    #1;
    imem_ready    = ($urandom_range(99) < ready_pct);
    if_ready      = ($urandom_range(99) < pop_pct);
    rv            = (mem_q.size() > 0) && ($urandom_range(99) < rsp_pct);
    imem_rvalid   = rv;
    imem_rdata    = rv ? instr_of(mem_q[0]) : $urandom;
    branch_taken  = br_req;
    branch_target = br_tgt;
    br_req        = 1'b0;
    #1;
    exp_valid = (buf_q.size() > 0) && !branch_taken;
    chk("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      chk("if_pc", if_pc, buf_q[0].pc);
      chk("if_instruction", if_instruction, buf_q[0].instr);
    end
    exp_req = (discard == 0) && ((mem_q.size() + buf_q.size()) < DEPTH) && !branch_taken;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);

    if (imem_req && imem_ready) issue_log.push_back(imem_addr);
    if (if_valid && if_ready) begin
      dut_pops++;
      pop_log.push_back(if_pc);
      pop_cyc.push_back(cyc);
      if (verbose) $display("[TB] pop pc=0x%0h instr=0x%08h", if_pc, if_instruction);
    end

    raddr = '0;
    if (rv) raddr = mem_q.pop_front();
    if (branch_taken) begin
      buf_q.delete();
      discard = mem_q.size();
      exp_pc  = branch_target;
      model_flushes++;
    end else begin
      if (exp_valid && if_ready) begin
        void'(buf_q.pop_front());
        model_pops++;
      end
      if (rv) begin
        if (discard > 0) begin
          discard--;
        end else begin
          e.pc    = raddr;
          e.instr = instr_of(raddr);
          buf_q.push_back(e);
        end
      end
      if (exp_req && imem_ready) begin
        mem_q.push_back(exp_pc);
        exp_pc = exp_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset        = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    branch_taken = 1'b0;
    if_ready     = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instruction", if_instruction, 32'h0);
    chk("rst_if_pc", if_pc, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushes", perf_flushes, 32'h0);
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("idle_imem_req", imem_req, 1'b0);
    model_reset();
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_pct = 0;
    rsp_pct   = 100;
    pop_pct   = 100;
    while ((mem_q.size() > 0 || buf_q.size() > 0) && n < 64) begin
      step();
      n++;
    end
    chk("drain_bound", (mem_q.size() + buf_q.size()), 0);
  endtask

  task automatic clear_logs();
    issue_log.delete();
    pop_log.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pops_before;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    dut_pops = 0;
    br_req  = 1'b0;
    br_tgt  = '0;
    verbose = 1'b1;
    model_reset();

    // Straight-line fetch with single-cycle memory.
    do_reset();
    clear_logs();
    ready_pct = 100; rsp_pct = 100; pop_pct = 100;
    repeat (12) step();
    chk("seq_len", (pop_log.size() >= 4), 1'b1);
    if (pop_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("seq_pc", pop_log[i], 64'(4 * i));
        if (i > 0) chk("seq_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);
      end
    end

    // Consumer stall: buffer fills to DEPTH and issuing stops.
    drain();
    clear_logs();
    ready_pct = 100; rsp_pct = 100; pop_pct = 0;
    repeat (20) step();
    chk("stall_issues", issue_log.size(), DEPTH);
    chk("stall_imem_req", imem_req, 1'b0);
    pop_pct = 100;
    pop_log.delete();
    repeat (6) step();
    chk("stall_pop_len", (pop_log.size() >= DEPTH), 1'b1);
    if (pop_log.size() >= DEPTH)
      for (int i = 0; i < DEPTH; i++) chk("stall_pop_order", pop_log[i], issue_log[i]);
    chk("stall_resume", (issue_log.size() > DEPTH), 1'b1);

    // Redirect with two requests in flight.
    drain();
    ready_pct = 100; rsp_pct = 0; pop_pct = 100;
    n = 0;
    while (mem_q.size() < 2 && n < 10) begin step(); n++; end
    chk("br_outstanding", mem_q.size(), 2);
    br_req = 1'b1; br_tgt = 64'h100;
    step();
    clear_logs();
    rsp_pct = 100;
    repeat (10) step();
    chk("br_issue_len", (issue_log.size() > 0), 1'b1);
    if (issue_log.size() > 0) chk("br_first_issue", issue_log[0], 64'h100);
    chk("br_pop_len", (pop_log.size() > 0), 1'b1);
    if (pop_log.size() > 0) chk("br_first_pop", pop_log[0], 64'h100);

    // Redirect coinciding with a response and a would-be pop.
    drain();
    ready_pct = 100; rsp_pct = 100; pop_pct = 0;
    n = 0;
    while (!(buf_q.size() > 0 && mem_q.size() > 0) && n < 10) begin step(); n++; end
    pop_pct = 100;
    br_req = 1'b1; br_tgt = 64'h200;
    pops_before = dut_pops;
    step();
    chk("brc_rvalid_seen", imem_rvalid, 1'b1);
    chk("brc_no_pop", dut_pops - pops_before, 0);
    ready_pct = 0; rsp_pct = 0;
    step();
    chk("brc_buf_empty", if_valid, 1'b0);

    // PC wrap at the top of the address space.
    drain();
    ready_pct = 100; rsp_pct = 100; pop_pct = 100;
    clear_logs();
    br_req = 1'b1; br_tgt = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    repeat (6) step();
    chk("wrap_len", (issue_log.size() >= 3), 1'b1);
    if (issue_log.size() >= 3) begin
      chk("wrap_fff8", issue_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_fffc", issue_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_zero", issue_log[2], 64'h0);
    end

    // Random traffic with random redirects.
    verbose = 1'b0;
    for (int blk = 0; blk < 30; blk++) begin
      ready_pct = $urandom_range(100, 20);
      rsp_pct   = $urandom_range(100, 20);
      pop_pct   = $urandom_range(100, 10);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(99) < 4) begin
          br_req = 1'b1;
          br_tgt = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                            : ({$urandom, $urandom} & ~64'h3);
        end
        step();
      end
      if (blk == 15) begin
        // Reset with requests in flight; stale responses must be ignored.
        do_reset();
        for (int i = 0; i < 4; i++) begin
          @(posedge clock);
          #1;
          imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; if_ready = 1'b1;
          branch_taken = 1'b0;
          #1;
          chk("stale_drop", if_valid, 1'b0);
        end
        imem_rvalid = 1'b0;
      end
    end
    drain();
    step();
    chk("final_pops", model_pops, dut_pops_since_reset_check());
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched_run", perf_fetched, model_pops);
    chk("perf_flushes_run", perf_flushes, model_flushes);

    // Exactly 10 pops then 3 redirects.
    verbose = 1'b1;
    do_reset();
    ready_pct = 100; rsp_pct = 100; pop_pct = 100;
    pops_before = dut_pops;
    n = 0;
    while ((dut_pops - pops_before) < 10 && n < 40) begin step(); n++; end
    pop_pct = 0; ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      br_req = 1'b1; br_tgt = 64'h400 + 64'(16 * i);
      step();
      repeat (3) step();
    end
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_flushes_3", perf_flushes, 32'd3);
    ready_pct = 100; rsp_pct = 100; pop_pct = 100;
    repeat (5) step();
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Pops the DUT delivered since the last reset, counted from its own handshake.
  int dut_pops_at_reset;
  always @(negedge reset) dut_pops_at_reset = dut_pops;

  function automatic int dut_pops_since_reset_check();
    return dut_pops - dut_pops_at_reset;
  endfunction

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch buffer entries and maximum outstanding requests; power of 2, range 2 to 16.
REQ-002 SHALL have parameter RESET_PC, default 64'h0: PC loaded at reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: imem_req  output  1  instruction memory request valid.
REQ-007 Port: imem_addr  output  64  request byte address.
REQ-008 Port: imem_ready  input  1  memory accepts the request this cycle.
REQ-009 Port: imem_rvalid  input  1  response valid; responses return in request order.
REQ-010 Port: imem_rdata  input  32  response instruction word.
REQ-011 Port: branch_taken  input  1  redirect from the MEM stage (branch AND zero).
REQ-012 Port: branch_target  input  64  redirect PC.
REQ-013 Port: if_valid  output  1  buffer head valid toward the IF/ID register.
REQ-014 Port: if_ready  input  1  IF/ID register not stalled.
REQ-015 Port: if_instruction  output  32  head instruction.
REQ-016 Port: if_pc  output  64  PC of the head instruction.

Function
REQ-017 SHALL accept a request (issue) on the cycle imem_req AND imem_ready; the PC then advances by 4, with 64-bit wrap from 0xFFFF_FFFF_FFFF_FFFC to 0.
REQ-018 SHALL assert imem_req only in FETCH, and only when outstanding + occupancy < DEPTH; imem_addr SHALL equal the PC.
REQ-019 SHALL record each issued PC in order and push {PC, imem_rdata} into the buffer on every non-discarded imem_rvalid.
REQ-020 SHALL treat if_valid AND if_ready as a pop; the head appears on the cycle after the push (1-cycle minimum latency from rvalid).
REQ-021 SHALL allow a push and a pop in the same cycle when the buffer is full, with occupancy unchanged.
REQ-022 SHALL force if_valid to 0 in any cycle where branch_taken is 1, so that no pop occurs.
REQ-023 On branch_taken: SHALL empty the buffer, load PC with branch_target, and set the discard count to outstanding minus any response arriving that cycle; a response in the same cycle SHALL be dropped.
REQ-024 FSM states: IDLE, FETCH, FLUSH. IDLE goes to FETCH after one cycle. FETCH goes to FLUSH on branch_taken with discard count > 0, and otherwise stays in FETCH. FLUSH issues nothing and decrements the discard count on each imem_rvalid, then goes to FETCH when the count reaches 0.
REQ-025 A branch_taken during FLUSH SHALL reload PC and re-apply REQ-023, adding no further discards.
REQ-026 SHALL never issue a request with imem_req asserted in the same cycle as branch_taken.

Reset
REQ-027 Reset asserted SHALL give: state IDLE, PC=RESET_PC, buffer empty, outstanding=0, discard=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instruction=0, if_pc=0.
REQ-028 Reset asserted mid-operation SHALL abandon in-flight requests; responses that arrive after release SHALL be ignored until the first issue after reset.

Configuration
REQ-029 Macro IFU_PERF_CNT_EN: when defined, SHALL add output ports perf_fetched (32 bits, pops) and perf_flushes (32 bits, branch_taken events). Both saturate at all-ones and reset to 0. When undefined, these ports and their counters SHALL be absent, and function SHALL be otherwise identical.

Structure
REQ-030 Package cpu_pipeline_pkg SHALL hold XLEN=64, INSTR_W=32, PC_INC=4, and the typedef ifu_state_t {IDLE, FETCH, FLUSH}.
REQ-031 A sub-module fetch_fifo (DEPTH x {64-bit PC, 32-bit instruction}, with push, pop, clear, full, empty and count) SHALL hold the buffer; the issued-PC queue SHALL reuse it.

Verification
REQ-032 Reset with RESET_PC=0, imem_ready=1, single-cycle responses -> pops with if_pc 0, 4, 8, 12 and matching instructions on consecutive cycles.
REQ-033 if_ready=0 held with DEPTH=4 -> exactly 4 issues, then imem_req=0; releasing if_ready -> 4 pops in order, then issuing resumes.
REQ-034 branch_taken with target 0x100 and 2 outstanding -> FLUSH; the next 2 responses are dropped; the first issue after that is at 0x100, and the first pop has if_pc=0x100.
REQ-035 branch_taken coincident with imem_rvalid and a would-be pop -> no pop, response dropped, buffer empty next cycle.
REQ-036 PC at 0xFFFF_FFFF_FFFF_FFFC -> next issue at 0x0.
REQ-037 With IFU_PERF_CNT_EN: 10 pops and 3 redirects -> perf_fetched=10, perf_flushes=3; reset mid-run -> both read 0.
